// File: rtl/nic_vc_allocator_pkg.sv
// Shared constants and helpers for the NIC VC allocator: vnet/VC counts,
// clog2 helper and VC index mapping.
package nic_vc_allocator_pkg;

  localparam int NIC_N_OF_VN = 3;

  localparam int NIC_N_OF_VC = 2;

  // Width helper that never returns 0, so single-entry fields stay 1 bit wide.
  function automatic int nic_clog2(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  function automatic int vc_index(input int vnet, input int vc, input int n_of_vc);
    return vnet * n_of_vc + vc;
  endfunction

endpackage

// File: rtl/nic_vc_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after i_ptr wins,
// wrapping modulo N_REQ. The pointer register lives in the parent.
module nic_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt
);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = (int'(i_ptr) + i) % N_REQ;
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nic_vc_allocator.sv
// VC allocator for the NIC injection side: per-vnet round-robin over buffers, lowest free VC.
// Optional sticky protocol checker built only when NIC_VA_ERROR_CHECK_EN is defined.
module nic_vc_allocator
    import nic_vc_allocator_pkg::*;
#(
    parameter int N_BUFFERS      = 2,
    parameter int N_OF_VN        = NIC_N_OF_VN,
    parameter int N_OF_VC        = NIC_N_OF_VC,
    parameter int N_BITS_VNET_ID = nic_clog2(N_OF_VN),
    parameter int N_BITS_VC_ID   = N_OF_VC * N_OF_VN
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_BUFFERS-1:0]                r_va_i,
    input  logic [N_BUFFERS*N_BITS_VNET_ID-1:0] vnet_id_i,
    output logic [N_BUFFERS-1:0]                g_va_o,
    output logic [N_BUFFERS*N_BITS_VC_ID-1:0]   vc_id_o,
    input  logic [N_BUFFERS-1:0]                release_i,
    input  logic [N_BUFFERS*N_BITS_VC_ID-1:0]   release_vc_id_i,
    output logic [N_BITS_VC_ID-1:0]             vc_busy_o,
    output logic                                error_o
);

    localparam int PTR_W = nic_clog2(N_BUFFERS);

    logic [N_BUFFERS-1:0]              r_g_va;
    logic [N_BUFFERS*N_BITS_VC_ID-1:0] r_vc_id;
    logic [N_BITS_VC_ID-1:0]           r_vc_busy;
    logic [PTR_W-1:0]                  r_rr_ptr [N_OF_VN];

    logic [N_BITS_VNET_ID-1:0]         w_vnet [N_BUFFERS];
    logic [N_BUFFERS-1:0]              w_req [N_OF_VN];
    logic [N_BUFFERS-1:0]              w_win [N_OF_VN];
    logic [N_OF_VN-1:0]                w_cand_found;
    logic [N_BITS_VC_ID-1:0]           w_cand_oh [N_OF_VN];
    logic [N_BITS_VC_ID-1:0]           w_set;
    logic [N_BITS_VC_ID-1:0]           w_clr;
    logic [N_BUFFERS-1:0]              w_g_va_nxt;
    logic [N_BUFFERS*N_BITS_VC_ID-1:0] w_vc_id_nxt;
    logic [PTR_W-1:0]                  w_ptr_nxt [N_OF_VN];

    for (genvar b = 0; b < N_BUFFERS; b++) begin : g_vnet_slice
        assign w_vnet[b] = vnet_id_i[b*N_BITS_VNET_ID +: N_BITS_VNET_ID];
    end

    // A buffer is masked during its own grant cycle so a held request is not granted twice.
    always_comb begin
        for (int v = 0; v < N_OF_VN; v++) begin
            w_req[v] = '0;
            for (int b = 0; b < N_BUFFERS; b++) begin
                w_req[v][b] = r_va_i[b] && !r_g_va[b] && (int'(w_vnet[b]) == v);
            end
        end
    end

    always_comb begin
        for (int v = 0; v < N_OF_VN; v++) begin
            w_cand_oh[v]    = '0;
            w_cand_found[v] = 1'b0;
            for (int c = N_OF_VC - 1; c >= 0; c--) begin
                if (!r_vc_busy[vc_index(v, c, N_OF_VC)]) begin
                    w_cand_oh[v]                           = '0;
                    w_cand_oh[v][vc_index(v, c, N_OF_VC)] = 1'b1;
                    w_cand_found[v]                        = 1'b1;
                end
            end
        end
    end

    for (genvar v = 0; v < N_OF_VN; v++) begin : g_arb
        nic_rr_arbiter #(
            .N_REQ (N_BUFFERS),
            .PTR_W (PTR_W)
        ) u_arb (
            .i_req (w_req[v]),
            .i_ptr (r_rr_ptr[v]),
            .o_gnt (w_win[v])
        );
    end

    always_comb begin
        w_set       = '0;
        w_clr       = '0;
        w_g_va_nxt  = '0;
        w_vc_id_nxt = '0;
        for (int v = 0; v < N_OF_VN; v++) begin
            w_ptr_nxt[v] = r_rr_ptr[v];
            if (w_cand_found[v] && (|w_win[v])) begin
                w_set = w_set | w_cand_oh[v];
                for (int b = 0; b < N_BUFFERS; b++) begin
                    if (w_win[v][b]) begin
                        w_g_va_nxt[b]                            = 1'b1;
                        w_vc_id_nxt[b*N_BITS_VC_ID +: N_BITS_VC_ID] = w_cand_oh[v];
                        w_ptr_nxt[v]                             = PTR_W'((b + 1) % N_BUFFERS);
                    end
                end
            end
        end
        for (int b = 0; b < N_BUFFERS; b++) begin
            if (release_i[b]) begin
                w_clr = w_clr | release_vc_id_i[b*N_BITS_VC_ID +: N_BITS_VC_ID];
            end
        end
    end

    // Set and clear never target the same bit: a VC being released is busy, so it is never a candidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g_va    <= '0;
            r_vc_id   <= '0;
            r_vc_busy <= '0;
            for (int v = 0; v < N_OF_VN; v++) begin
                r_rr_ptr[v] <= '0;
            end
        end else begin
            r_g_va    <= w_g_va_nxt;
            r_vc_id   <= w_vc_id_nxt;
            r_vc_busy <= (r_vc_busy & ~w_clr) | w_set;
            for (int v = 0; v < N_OF_VN; v++) begin
                r_rr_ptr[v] <= w_ptr_nxt[v];
            end
        end
    end

    assign g_va_o    = r_g_va;
    assign vc_id_o   = r_vc_id;
    assign vc_busy_o = r_vc_busy;

`ifdef NIC_VA_ERROR_CHECK_EN
    logic r_error;
    logic w_err_evt;

    always_comb begin
        w_err_evt = 1'b0;
        for (int b = 0; b < N_BUFFERS; b++) begin
            if (release_i[b] &&
                (($countones(release_vc_id_i[b*N_BITS_VC_ID +: N_BITS_VC_ID]) != 1) ||
                 (|(release_vc_id_i[b*N_BITS_VC_ID +: N_BITS_VC_ID] & ~r_vc_busy)))) begin
                w_err_evt = 1'b1;
            end
            if (r_va_i[b] && (int'(w_vnet[b]) >= N_OF_VN)) begin
                w_err_evt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error <= 1'b0;
        end else begin
            r_error <= r_error | w_err_evt;
        end
    end

    assign error_o = r_error;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_nic_vc_allocator.sv
// Directed bench for nic_vc_allocator (N_BUFFERS=2, N_OF_VN=3, N_OF_VC=2).
// Expected error_o follows whether NIC_VA_ERROR_CHECK_EN is defined.
module tb_nic_vc_allocator;

    localparam int NB = 2;
    localparam int NV = 3;
    localparam int NC = 2;
    localparam int VW = 2;
    localparam int CW = 6;

    localparam logic EXP_ERR =
`ifdef NIC_VA_ERROR_CHECK_EN
        1'b1;
`else
        1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NB-1:0]     r_va_i = '0;
    logic [NB*VW-1:0]  vnet_id_i = '0;
    logic [NB-1:0]     g_va_o;
    logic [NB*CW-1:0]  vc_id_o;
    logic [NB-1:0]     release_i = '0;
    logic [NB*CW-1:0]  release_vc_id_i = '0;
    logic [CW-1:0]     vc_busy_o;
    logic              error_o;

    int n_vec = 0;
    int n_err = 0;

    nic_vc_allocator #(
        .N_BUFFERS      (NB),
        .N_OF_VN        (NV),
        .N_OF_VC        (NC),
        .N_BITS_VNET_ID (VW),
        .N_BITS_VC_ID   (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .r_va_i          (r_va_i),
        .vnet_id_i       (vnet_id_i),
        .g_va_o          (g_va_o),
        .vc_id_o         (vc_id_o),
        .release_i       (release_i),
        .release_vc_id_i (release_vc_id_i),
        .vc_busy_o       (vc_busy_o),
        .error_o         (error_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [1:0] va, input logic [1:0] v0, input logic [1:0] v1);
        r_va_i    = va;
        vnet_id_i = {v1, v0};
    endtask

    task automatic rel(input logic [1:0] r, input logic [5:0] id0, input logic [5:0] id1);
        release_i       = r;
        release_vc_id_i = {id1, id0};
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_gva", 32'(g_va_o), 32'h0);
        chk("rst_vcid", 32'(vc_id_o), 32'h0);
        chk("rst_busy", 32'(vc_busy_o), 32'h0);
        chk("rst_err", 32'(error_o), 32'h0);
        rst = 1'b0;
        tick();

        // single request, buffer 0 on vnet 1
        req(2'b01, 2'd1, 2'd0);
        tick();
        chk("single_gva", 32'(g_va_o), 32'h1);
        chk("single_vc0", 32'(vc_id_o[5:0]), 32'b000100);
        chk("single_busy", 32'(vc_busy_o), 32'b000100);
        req(2'b00, 2'd0, 2'd0);
        tick();
        chk("single_gva_1cyc", 32'(g_va_o), 32'h0);
        chk("single_busy_hold", 32'(vc_busy_o), 32'b000100);
        rel(2'b01, 6'b000100, 6'b0);
        tick();
        rel(2'b00, 6'b0, 6'b0);
        chk("single_release", 32'(vc_busy_o), 32'h0);

        // contention on vnet 0
        req(2'b11, 2'd0, 2'd0);
        tick();
        chk("cont1_gva", 32'(g_va_o), 32'b01);
        chk("cont1_vc0", 32'(vc_id_o[5:0]), 32'b000001);
        chk("cont1_busy", 32'(vc_busy_o), 32'b000001);
        req(2'b10, 2'd0, 2'd0);
        tick();
        chk("cont2_gva", 32'(g_va_o), 32'b10);
        chk("cont2_vc1", 32'(vc_id_o[11:6]), 32'b000010);
        chk("cont2_busy", 32'(vc_busy_o), 32'b000011);
        req(2'b00, 2'd0, 2'd0);
        tick();
        chk("cont3_gva", 32'(g_va_o), 32'b00);
        rel(2'b11, 6'b000001, 6'b000010);
        tick();
        rel(2'b00, 6'b0, 6'b0);
        chk("cont_rel_busy", 32'(vc_busy_o), 32'h0);

        // round-robin: buffer 0 served, then on repeat buffer 1 goes first
        req(2'b11, 2'd0, 2'd0);
        tick();
        chk("rr1_gva", 32'(g_va_o), 32'b01);
        chk("rr1_vc0", 32'(vc_id_o[5:0]), 32'b000001);
        req(2'b00, 2'd0, 2'd0);
        rel(2'b01, 6'b000001, 6'b0);
        tick();
        rel(2'b00, 6'b0, 6'b0);
        chk("rr1_rel_busy", 32'(vc_busy_o), 32'h0);
        req(2'b11, 2'd0, 2'd0);
        tick();
        chk("rr2_gva", 32'(g_va_o), 32'b10);
        chk("rr2_vc1", 32'(vc_id_o[11:6]), 32'b000001);
        req(2'b00, 2'd0, 2'd0);
        rel(2'b10, 6'b0, 6'b000001);
        tick();
        rel(2'b00, 6'b0, 6'b0);
        chk("rr2_rel_busy", 32'(vc_busy_o), 32'h0);

        // exhaustion of vnet 2
        req(2'b01, 2'd2, 2'd0);
        tick();
        chk("exh_a_vc0", 32'(vc_id_o[5:0]), 32'b010000);
        req(2'b00, 2'd2, 2'd0);
        tick();
        req(2'b01, 2'd2, 2'd0);
        tick();
        chk("exh_b_vc0", 32'(vc_id_o[5:0]), 32'b100000);
        chk("exh_busy", 32'(vc_busy_o), 32'b110000);
        req(2'b10, 2'd0, 2'd2);
        tick();
        chk("exh_wait1", 32'(g_va_o), 32'b00);
        tick();
        chk("exh_wait2", 32'(g_va_o), 32'b00);
        rel(2'b01, 6'b010000, 6'b0);
        tick();
        rel(2'b00, 6'b0, 6'b0);
        chk("exh_t1_gva", 32'(g_va_o), 32'b00);
        chk("exh_t1_busy", 32'(vc_busy_o), 32'b100000);
        tick();
        chk("exh_t2_gva", 32'(g_va_o), 32'b10);
        chk("exh_t2_vc1", 32'(vc_id_o[11:6]), 32'b010000);
        chk("exh_t2_busy", 32'(vc_busy_o), 32'b110000);
        req(2'b00, 2'd0, 2'd0);
        rel(2'b11, 6'b100000, 6'b010000);
        tick();
        rel(2'b00, 6'b0, 6'b0);
        chk("exh_clear", 32'(vc_busy_o), 32'h0);

        // parallel vnets
        req(2'b11, 2'd0, 2'd2);
        tick();
        chk("par_gva", 32'(g_va_o), 32'b11);
        chk("par_vc0", 32'(vc_id_o[5:0]), 32'b000001);
        chk("par_vc1", 32'(vc_id_o[11:6]), 32'b010000);
        chk("par_busy", 32'(vc_busy_o), 32'b010001);
        req(2'b00, 2'd0, 2'd0);
        rel(2'b11, 6'b000001, 6'b010000);
        tick();
        rel(2'b00, 6'b0, 6'b0);
        chk("par_clear", 32'(vc_busy_o), 32'h0);

        // out-of-range vnet is never granted
        req(2'b01, 2'd3, 2'd0);
        tick();
        chk("oor_gva", 32'(g_va_o), 32'b00);
        tick();
        chk("oor_gva2", 32'(g_va_o), 32'b00);
        req(2'b00, 2'd0, 2'd0);

        // release of a free VC
        rel(2'b01, 6'b000010, 6'b0);
        tick();
        rel(2'b00, 6'b0, 6'b0);
        chk("err_set", 32'(error_o), 32'(EXP_ERR));
        tick();
        chk("err_sticky", 32'(error_o), 32'(EXP_ERR));
        chk("err_busy", 32'(vc_busy_o), 32'h0);

        // reset mid-grant
        req(2'b01, 2'd0, 2'd0);
        tick();
        chk("mid_gva", 32'(g_va_o), 32'b01);
        chk("mid_busy", 32'(vc_busy_o), 32'b000001);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_gva", 32'(g_va_o), 32'h0);
        chk("mid_rst_busy", 32'(vc_busy_o), 32'h0);
        chk("mid_rst_err", 32'(error_o), 32'h0);
        req(2'b00, 2'd0, 2'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_gva", 32'(g_va_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
